// File: rtl/gf26_rs_encoder.sv
// Systematic RS encoder over GF(2^6) (x^6+x+1), generator roots alpha^1..alpha^N_PARITY.
// Optional macro RS_PARITY_BUS_EN adds a parallel parity_bus snapshot output.
module gf26_rs_encoder #(
  parameter int SYM_W    = 6,
  parameter int N_PARITY = 8,
  parameter int K_SYMS   = 55
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [SYM_W-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [SYM_W-1:0] code_out,
  output logic             code_valid,
  output logic             finishFlag
`ifdef RS_PARITY_BUS_EN
  ,
  output logic [N_PARITY*SYM_W-1:0] parity_bus
`endif
);

  localparam int CNT_W  = $clog2(K_SYMS + 1);
  localparam int PCNT_W = $clog2(N_PARITY + 1);
  localparam logic [SYM_W-1:0] PRIM_LOW = SYM_W'(3);

  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < SYM_W; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? PRIM_LOW : '0);
    end
    return p;
  endfunction

  // Expands prod (x + alpha^i); the monic x^N_PARITY term is implicit.
  function automatic logic [N_PARITY*SYM_W-1:0] gen_coefs();
    logic [SYM_W-1:0]          g [0:N_PARITY];
    logic [SYM_W-1:0]          a;
    logic [N_PARITY*SYM_W-1:0] r;
    for (int j = 0; j <= N_PARITY; j++) g[j] = '0;
    g[0] = SYM_W'(1);
    a    = SYM_W'(1);
    for (int i = 1; i <= N_PARITY; i++) begin
      a = gf_mul(a, SYM_W'(2));
      for (int j = i; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], a);
      g[0] = gf_mul(g[0], a);
    end
    r = '0;
    for (int j = 0; j < N_PARITY; j++) r[j*SYM_W +: SYM_W] = g[j];
    return r;
  endfunction

  localparam logic [N_PARITY*SYM_W-1:0] G_FLAT = gen_coefs();

  typedef enum logic [1:0] {IDLE, LOAD, PARITY, FINISH} state_t;

  state_t                           state_reg, state_next;
  logic [N_PARITY-1:0][SYM_W-1:0]   lfsr_reg, lfsr_next, lfsr_upd, fb_prod;
  logic [CNT_W-1:0]                 sym_cnt_reg, sym_cnt_next;
  logic [PCNT_W-1:0]                par_cnt_reg, par_cnt_next;
  logic                             start_d_reg;
  logic [SYM_W-1:0]                 code_out_reg, code_out_next;
  logic                             code_valid_reg, code_valid_next;
  logic                             finish_reg, finish_next;
  logic [SYM_W-1:0]                 fb;
  logic                             start_edge;
`ifdef RS_PARITY_BUS_EN
  logic [N_PARITY*SYM_W-1:0]        parity_bus_reg, parity_bus_next;
`endif

  assign fb         = data_in ^ lfsr_reg[N_PARITY-1];
  assign start_edge = start & ~start_d_reg;

  // Constant-coefficient multipliers collapse to XOR trees at elaboration.
  for (genvar gi = 0; gi < N_PARITY; gi++) begin : g_stage
    assign fb_prod[gi] = gf_mul(fb, G_FLAT[gi*SYM_W +: SYM_W]);
    if (gi == 0) begin : g_first
      assign lfsr_upd[gi] = fb_prod[gi];
    end else begin : g_rest
      assign lfsr_upd[gi] = lfsr_reg[gi-1] ^ fb_prod[gi];
    end
  end

  always_comb begin
    state_next      = state_reg;
    lfsr_next       = lfsr_reg;
    sym_cnt_next    = sym_cnt_reg;
    par_cnt_next    = par_cnt_reg;
    code_out_next   = '0;
    code_valid_next = 1'b0;
    finish_next     = 1'b0;
    data_ready      = 1'b0;
`ifdef RS_PARITY_BUS_EN
    parity_bus_next = parity_bus_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          lfsr_next    = '0;
          sym_cnt_next = '0;
          par_cnt_next = '0;
          state_next   = LOAD;
`ifdef RS_PARITY_BUS_EN
          parity_bus_next = '0;
`endif
        end
      end
      LOAD: begin
        data_ready = 1'b1;
        if (data_valid) begin
          lfsr_next       = lfsr_upd;
          sym_cnt_next    = sym_cnt_reg + CNT_W'(1);
          code_out_next   = data_in;
          code_valid_next = 1'b1;
          if (sym_cnt_reg == CNT_W'(K_SYMS - 1)) begin
            state_next = PARITY;
`ifdef RS_PARITY_BUS_EN
            parity_bus_next = lfsr_upd;
`endif
          end
        end
      end
      PARITY: begin
        code_out_next   = lfsr_reg[N_PARITY-1];
        code_valid_next = 1'b1;
        lfsr_next       = {lfsr_reg[N_PARITY-2:0], SYM_W'(0)};
        par_cnt_next    = par_cnt_reg + PCNT_W'(1);
        if (par_cnt_reg == PCNT_W'(N_PARITY - 1)) state_next = FINISH;
      end
      FINISH: begin
        finish_next = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      lfsr_reg       <= '0;
      sym_cnt_reg    <= '0;
      par_cnt_reg    <= '0;
      start_d_reg    <= 1'b0;
      code_out_reg   <= '0;
      code_valid_reg <= 1'b0;
      finish_reg     <= 1'b0;
`ifdef RS_PARITY_BUS_EN
      parity_bus_reg <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      lfsr_reg       <= lfsr_next;
      sym_cnt_reg    <= sym_cnt_next;
      par_cnt_reg    <= par_cnt_next;
      start_d_reg    <= start;
      code_out_reg   <= code_out_next;
      code_valid_reg <= code_valid_next;
      finish_reg     <= finish_next;
`ifdef RS_PARITY_BUS_EN
      parity_bus_reg <= parity_bus_next;
`endif
    end
  end

  assign code_out   = code_out_reg;
  assign code_valid = code_valid_reg;
  assign finishFlag = finish_reg;
`ifdef RS_PARITY_BUS_EN
  assign parity_bus = parity_bus_reg;
`endif

endmodule

// File: tb/tb_gf26_rs_encoder.sv
// Randomized bench for gf26_rs_encoder against a polynomial-division reference model.
module tb_gf26_rs_encoder;
  localparam int W  = 6;
  localparam int NP = 8;
  localparam int K  = 55;
  localparam int N  = K + NP;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready, code_valid, finishFlag;
  logic [W-1:0] code_out;
`ifdef RS_PARITY_BUS_EN
  logic [NP*W-1:0] parity_bus;
`endif

  gf26_rs_encoder #(.SYM_W(W), .N_PARITY(NP), .K_SYMS(K)) dut (
    .clk(clk), .resetN(resetN), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .code_out(code_out),
    .code_valid(code_valid), .finishFlag(finishFlag)
`ifdef RS_PARITY_BUS_EN
    , .parity_bus(parity_bus)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] cap_q[$];
  int first_v, last_v, fin_cnt, fin_cyc, c0, ncw;
  int exp_t[63];
  int log_t[64];
  int g_tb[NP+1];
  int msg[K];
  int ma[K];
  int mb[K];
  int mpar[NP];
  int prev[N];
  int par_a[NP];
  int par_b[NP];

  always @(negedge clk) begin
    if (code_valid) begin
      cap_q.push_back(code_out);
      if (cap_q.size() == 1) first_v = cyc;
      last_v = cyc;
    end
    if (finishFlag) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 63];
  endfunction

  task automatic build_field();
    int e;
    int t[NP+1];
    e = 1;
    for (int i = 0; i < 63; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e << 1;
      if ((e & 64) != 0) e = e ^ 67;
    end
    for (int j = 0; j <= NP; j++) g_tb[j] = 0;
    g_tb[0] = 1;
    for (int i = 1; i <= NP; i++) begin
      for (int j = 0; j <= NP; j++) t[j] = 0;
      for (int j = 0; j < i; j++) begin
        t[j+1] ^= g_tb[j];
        t[j]   ^= gmul(g_tb[j], exp_t[i]);
      end
      for (int j = 0; j <= NP; j++) g_tb[j] = t[j];
    end
  endtask

  // Remainder of m(x)*x^NP divided by g(x); mpar[0] is the highest-degree parity.
  task automatic model_parity();
    int c[N];
    int coef;
    for (int d = 0; d < N; d++) c[d] = 0;
    for (int i = 0; i < K; i++) c[N-1-i] = msg[i];
    for (int d = N - 1; d >= NP; d--) begin
      coef = c[d];
      if (coef != 0)
        for (int j = 0; j <= NP; j++) c[d-NP+j] ^= gmul(coef, g_tb[j]);
    end
    for (int j = 0; j < NP; j++) mpar[j] = c[NP-1-j];
  endtask

  function automatic int got_sym(input int i);
    if (i < cap_q.size()) return int'(cap_q[i]);
    return 255;
  endfunction

  // Encode msg[]; returns early (no finish wait) when rst_at >= 0 is reached.
  task automatic encode(input int gap_pct, input bit hold_start, input int rst_at);
    int idx, budget, w;
    model_parity();
    cap_q.delete();
    fin_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < K && budget < 2000) begin
      if (rst_at >= 0 && idx == rst_at) return;
      if (data_ready && ($urandom_range(99) >= gap_pct)) begin
        data_valid = 1'b1;
        data_in = W'(msg[idx]);
        if (idx == 0) c0 = cyc;
        idx++;
      end else begin
        data_valid = 1'b0;
        data_in = W'($urandom);
      end
      @(negedge clk);
      budget++;
    end
    chk("feed_count", idx, K);
    data_valid = 1'b1;
    w = 0;
    while (!finishFlag && w < 200) begin
      data_in = W'($urandom);
      @(negedge clk);
      w++;
    end
    chk("finish_seen", finishFlag, 1);
`ifdef RS_PARITY_BUS_EN
    for (int j = 0; j < NP; j++)
      chk("parity_bus", parity_bus[(NP-1-j)*W +: W], mpar[j]);
`endif
    @(negedge clk);
    data_valid = 1'b0;
    chk("finish_pulse_end", finishFlag, 0);
    if (hold_start) begin
      @(negedge clk);
      chk("no_retrigger", data_ready, 0);
      start = 1'b0;
    end
    chk("finish_count", fin_cnt, 1);
    chk("cw_len", cap_q.size(), N);
    for (int i = 0; i < N; i++)
      chk($sformatf("sym%0d", i), got_sym(i), (i < K) ? msg[i] : mpar[i-K]);
    for (int r = 1; r <= NP; r++) begin
      int s;
      s = 0;
      for (int i = 0; i < cap_q.size(); i++) s = gmul(s, exp_t[r]) ^ int'(cap_q[i]);
      chk($sformatf("syndrome%0d", r), s, 0);
    end
    ncw++;
    $display("codeword %0d: gap=%0d%% syms=%0d first_accept_cyc=%0d finish_cyc=%0d",
             ncw, gap_pct, cap_q.size(), c0, fin_cyc);
  endtask

  task automatic rand_msg();
    for (int i = 0; i < K; i++) msg[i] = $urandom_range(63);
  endtask

  initial begin
    ncw = 0;
    build_field();
    #1;
    chk("rst_ready", data_ready, 0);
    chk("rst_code_out", code_out, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_finish", finishFlag, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", data_ready, 0);

    // All-zero message with exact latency checks
    for (int i = 0; i < K; i++) msg[i] = 0;
    encode(0, 1'b0, -1);
    chk("latency", fin_cyc - c0, 64);
    chk("contiguous_span", last_v - first_v, N - 1);
    chk("finish_after_last", fin_cyc - last_v, 1);

    // Impulse: parity equals g_7..g_0
    msg[K-1] = 1;
    encode(0, 1'b0, -1);
    for (int j = 0; j < NP; j++)
      chk($sformatf("impulse_g%0d", NP-1-j), got_sym(K+j), g_tb[NP-1-j]);

    // Gap-free versus gapped run of the same message, with start held high
    rand_msg();
    for (int i = 0; i < K; i++) ma[i] = msg[i];
    encode(0, 1'b0, -1);
    for (int i = 0; i < N; i++) prev[i] = got_sym(i);
    encode(30, 1'b1, -1);
    for (int i = 0; i < N; i++) chk($sformatf("gap_equiv%0d", i), got_sym(i), prev[i]);
    for (int j = 0; j < NP; j++) par_a[j] = got_sym(K+j);

    // Linearity
    rand_msg();
    for (int i = 0; i < K; i++) mb[i] = msg[i];
    encode(20, 1'b0, -1);
    for (int j = 0; j < NP; j++) par_b[j] = got_sym(K+j);
    for (int i = 0; i < K; i++) msg[i] = ma[i] ^ mb[i];
    encode(10, 1'b0, -1);
    for (int j = 0; j < NP; j++)
      chk($sformatf("linear%0d", j), got_sym(K+j), par_a[j] ^ par_b[j]);

    // Reset pulsed at symbol 20, then a full codeword
    rand_msg();
    encode(0, 1'b0, 20);
    resetN = 1'b0;
    #1;
    chk("abort_code_valid", code_valid, 0);
    chk("abort_code_out", code_out, 0);
    chk("abort_finish", finishFlag, 0);
    chk("abort_ready", data_ready, 0);
    @(negedge clk);
    resetN = 1'b1;
    data_valid = 1'b1;
    fin_cnt = 0;
    cap_q.delete();
    repeat (4) @(negedge clk);
    data_valid = 1'b0;
    chk("abort_no_emit", cap_q.size(), 0);
    chk("abort_no_finish", fin_cnt, 0);
    rand_msg();
    encode(0, 1'b0, -1);

    for (int n = 0; n < 3; n++) begin
      rand_msg();
      encode(30, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
